// File: rtl/col_collect.sv
`default_nettype none
// ============================================================================
//  Module   : col_collect
//  Purpose  : Assembles four 32-bit column beats (rows 0..3 on in_1..in_4)
//             into a 128-bit AES state. A separate output holding register
//             keeps the last completed state stable while the next block is
//             being collected.
//  Ports    : clk, rst_n        - clock, asynchronous active-low reset
//             start             - begin a new block, aborting any partial one
//             in_valid/in_ready - column beat handshake
//             in_1..in_4        - column bytes, row 0..3
//             inv_sr            - InvShiftRows placement (used only when
//                                 INV_SR_EN is defined)
//             col_idx           - column the next accepted beat writes to
//             state_out         - last completed state, column c at
//                                 [127-32c -: 32], row 0 in the MSB byte
//             state_valid       - one-cycle pulse when state_out updates
//  Options  : `define INV_SR_EN to honour inv_sr; row r of a beat for
//             column c is then written to column (c+r) mod 4.
//  Revision : 1.0 - initial release
// ============================================================================
module col_collect (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_1,
    input  logic [7:0]   in_2,
    input  logic [7:0]   in_3,
    input  logic [7:0]   in_4,
    input  logic         inv_sr,
    output logic [1:0]   col_idx,
    output logic [127:0] state_out,
    output logic         state_valid
);

    localparam logic [0:0] c_IDLE    = 1'b0;
    localparam logic [0:0] c_COLLECT = 1'b1;

    logic [0:0]   r_state;
    logic [0:0]   w_state_next;
    logic [1:0]   r_col_idx;
    logic [127:0] r_working;
    logic [127:0] r_state_out;
    logic         r_state_valid;
    logic [127:0] w_working_next;
    logic         w_accept;
    logic         w_last;
    logic         w_inv;

    logic [7:0]   w_byte [4];
    logic [1:0]   w_dst  [4];
    logic [6:0]   w_lsb  [4];

`ifdef INV_SR_EN
    assign w_inv = inv_sr;
`else
    logic w_unused_inv_sr;
    assign w_unused_inv_sr = inv_sr;
    assign w_inv           = 1'b0;
`endif

    assign w_byte[0] = in_1;
    assign w_byte[1] = in_2;
    assign w_byte[2] = in_3;
    assign w_byte[3] = in_4;

    // Destination column per row. The byte LSB position of (column d, row r)
    // is 8*(15-4d-r), which is simply {~d, ~r, 3'b000}.
    for (genvar r = 0; r < 4; r++) begin : g_row
        localparam logic [1:0] c_ROW = 2'(r);
        assign w_dst[r] = w_inv ? (r_col_idx + c_ROW) : r_col_idx;
        assign w_lsb[r] = {~w_dst[r], ~c_ROW, 3'b000};
    end

    // Working register with the current beat merged in; this is also what
    // gets copied to state_out on the completing beat, so column 3 lands
    // on the same edge.
    always_comb begin
        w_working_next = r_working;
        for (int r = 0; r < 4; r++) begin
            w_working_next[w_lsb[r] +: 8] = w_byte[r];
        end
    end

    // start has priority over any beat presented in the same cycle.
    assign w_accept = (r_state == c_COLLECT) && in_valid && !start;
    assign w_last   = w_accept && (r_col_idx == 2'd3);

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = c_COLLECT;
        end else if (w_last) begin
            w_state_next = c_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_col_idx     <= 2'd0;
            r_working     <= '0;
            r_state_out   <= '0;
            r_state_valid <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_state_valid <= 1'b0;
            if (start) begin
                r_col_idx <= 2'd0;
                r_working <= '0;
            end else if (w_accept) begin
                r_working <= w_working_next;
                r_col_idx <= r_col_idx + 2'd1;
                if (w_last) begin
                    r_state_out   <= w_working_next;
                    r_state_valid <= 1'b1;
                end
            end
        end
    end

    assign in_ready    = (r_state == c_COLLECT);
    assign col_idx     = r_col_idx;
    assign state_out   = r_state_out;
    assign state_valid = r_state_valid;

endmodule
`default_nettype wire

// File: tb/tb_col_collect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_col_collect
//  Purpose  : Self-checking bench for col_collect: table of full blocks plus
//             hand-written stall, abort, boundary and reset sequences. A
//             scoreboard queue holds the expected state_out of every block
//             and is popped on each state_valid pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_col_collect;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_1, in_2, in_3, in_4;
    logic         inv_sr;
    logic [1:0]   col_idx;
    logic [127:0] state_out;
    logic         state_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_q [$];
    logic [127:0] last_out;

    typedef struct {
        logic [31:0]  b0, b1, b2, b3;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [4];

    col_collect dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_1        (in_1),
        .in_2        (in_2),
        .in_3        (in_3),
        .in_4        (in_4),
        .inv_sr      (inv_sr),
        .col_idx     (col_idx),
        .state_out   (state_out),
        .state_valid (state_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every state_valid pulse must match the oldest expected block.
    always @(negedge clk) begin
        if (rst_n && state_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_valid", 128'(state_out), 128'h1);
            end else begin
                chk("sb_state_out", state_out, exp_q.pop_front());
            end
        end
    end

    // Drive one cycle of inputs, then sample #1 after the edge.
    task automatic cyc(input logic st, input logic v, input logic [31:0] d, input logic inv);
        start    = st;
        in_valid = v;
        {in_1, in_2, in_3, in_4} = d;
        inv_sr   = inv;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic run_block(input vec_t v);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("start_in_ready", 128'(in_ready), 128'd1);
        chk("start_col_idx", 128'(col_idx), 128'd0);
        exp_q.push_back(v.exp);
        cyc(1'b0, 1'b1, v.b0, v.inv);
        chk("col_idx_1", 128'(col_idx), 128'd1);
        cyc(1'b0, 1'b1, v.b1, v.inv);
        cyc(1'b0, 1'b1, v.b2, v.inv);
        chk("col_idx_3", 128'(col_idx), 128'd3);
        chk("no_early_valid", 128'(state_valid), 128'd0);
        cyc(1'b0, 1'b1, v.b3, v.inv);
        chk("valid_at_edge5", 128'(state_valid), 128'd1);
        chk("done_in_ready", 128'(in_ready), 128'd0);
        chk("done_col_idx", 128'(col_idx), 128'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("valid_one_cycle", 128'(state_valid), 128'd0);
        chk("held_out", state_out, v.exp);
        last_out = v.exp;
    endtask

    initial begin
        vecs[0] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff, 1'b0,
                    128'h00112233445566778899aabbccddeeff};
        vecs[2] = '{32'hffeeddcc, 32'hbbaa9988, 32'h77665544, 32'h33221100, 1'b0,
                    128'hffeeddccbbaa99887766554433221100};
`ifdef INV_SR_EN
        vecs[1] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff, 1'b1,
                    128'h00ddaa774411eebb885522ffcc996633};
        vecs[3] = '{32'hffeeddcc, 32'hbbaa9988, 32'h77665544, 32'h33221100, 1'b1,
                    128'hff225588bbee114477aadd00336699cc};
`else
        vecs[1] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff, 1'b1,
                    128'h00112233445566778899aabbccddeeff};
        vecs[3] = '{32'hffeeddcc, 32'hbbaa9988, 32'h77665544, 32'h33221100, 1'b1,
                    128'hffeeddccbbaa99887766554433221100};
`endif

        // ---------------- reset ----------------
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; inv_sr = 1'b0;
        {in_1, in_2, in_3, in_4} = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state_out", state_out, 128'h0);
        chk("rst_state_valid", 128'(state_valid), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_col_idx", 128'(col_idx), 128'd0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 32'h0, 1'b0);

        // ---------------- table of full blocks ----------------
        for (int i = 0; i < 4; i++) run_block(vecs[i]);

        // ---------------- stall between beats 1 and 2 ----------------
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        exp_q.push_back(vecs[0].exp);
        cyc(1'b0, 1'b1, vecs[0].b0, 1'b0);
        cyc(1'b0, 1'b1, vecs[0].b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 32'hdeadbeef, 1'b0);
            chk("stall_col_idx", 128'(col_idx), 128'd2);
            chk("stall_no_valid", 128'(state_valid), 128'd0);
        end
        cyc(1'b0, 1'b1, vecs[0].b2, 1'b0);
        cyc(1'b0, 1'b1, vecs[0].b3, 1'b0);
        chk("stall_valid", 128'(state_valid), 128'd1);
        chk("stall_out", state_out, vecs[0].exp);
        last_out = vecs[0].exp;
        cyc(1'b0, 1'b0, 32'h0, 1'b0);

        // ---------------- abort: restart after 2 beats ----------------
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'h01020304, 1'b0);
        cyc(1'b0, 1'b1, 32'h05060708, 1'b0);
        // restart with a concurrent beat that must be dropped
        cyc(1'b1, 1'b1, 32'h99999999, 1'b0);
        chk("abort_col_idx", 128'(col_idx), 128'd0);
        chk("abort_out_held", state_out, last_out);
        exp_q.push_back(vecs[2].exp);
        cyc(1'b0, 1'b1, vecs[2].b0, 1'b0);
        cyc(1'b0, 1'b1, vecs[2].b1, 1'b0);
        cyc(1'b0, 1'b1, vecs[2].b2, 1'b0);
        cyc(1'b0, 1'b1, vecs[2].b3, 1'b0);
        chk("abort_valid", 128'(state_valid), 128'd1);
        chk("abort_out", state_out, vecs[2].exp);
        last_out = vecs[2].exp;
        cyc(1'b0, 1'b0, 32'h0, 1'b0);

        // ---------------- start coincident with beat 3 ----------------
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'haaaaaaaa, 1'b0);
        cyc(1'b0, 1'b1, 32'hbbbbbbbb, 1'b0);
        cyc(1'b0, 1'b1, 32'hcccccccc, 1'b0);
        cyc(1'b1, 1'b1, 32'hdddddddd, 1'b0);
        chk("coinc_no_valid", 128'(state_valid), 128'd0);
        chk("coinc_col_idx", 128'(col_idx), 128'd0);
        chk("coinc_in_ready", 128'(in_ready), 128'd1);
        chk("coinc_out_held", state_out, last_out);
        // the restarted collection completes normally
        exp_q.push_back(vecs[0].exp);
        cyc(1'b0, 1'b1, vecs[0].b0, 1'b0);
        cyc(1'b0, 1'b1, vecs[0].b1, 1'b0);
        cyc(1'b0, 1'b1, vecs[0].b2, 1'b0);
        cyc(1'b0, 1'b1, vecs[0].b3, 1'b0);
        chk("coinc_then_out", state_out, vecs[0].exp);
        last_out = vecs[0].exp;

        // ---------------- in_valid while IDLE ----------------
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 1'b1, 32'h5a5a5a5a, 1'b0);
            chk("idle_col_idx", 128'(col_idx), 128'd0);
            chk("idle_in_ready", 128'(in_ready), 128'd0);
            chk("idle_no_valid", 128'(state_valid), 128'd0);
            chk("idle_out_held", state_out, last_out);
        end

        // ---------------- asynchronous reset mid-collection ----------------
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, vecs[2].b0, 1'b0);
        cyc(1'b0, 1'b1, vecs[2].b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state_out", state_out, 128'h0);
        chk("mid_rst_col_idx", 128'(col_idx), 128'd0);
        chk("mid_rst_in_ready", 128'(in_ready), 128'd0);
        chk("mid_rst_valid", 128'(state_valid), 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) cyc(1'b0, 1'b1, 32'h12345678, 1'b0);
        chk("post_rst_col_idx", 128'(col_idx), 128'd0);
        chk("post_rst_out", state_out, 128'h0);

        chk("sb_drained", 128'(exp_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/col_collect.md
# col_collect

Column-write counterpart of the ShiftRows column selector in the compact AES datapath. Accepts one 32-bit column (four bytes, row 0..3) per beat and assembles four beats into a 128-bit state register, so that the byte-serial round datapath can write back a full state. Runs a small collect FSM with a valid/ready input handshake and a separate output holding register, so a new block can be collected while the previous result is still stable. Optionally places bytes at InvShiftRows positions for the decryption path.

## Interface

- No parameters.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin collecting a new 128-bit state; aborts any partial collection.
- in_valid  input  1  column beat present.
- in_ready  output  1  block accepts a beat this cycle.
- in_1, in_2, in_3, in_4  input  8 each  column bytes, rows 0..3.
- inv_sr  input  1  apply InvShiftRows placement; ignored unless INV_SR_EN is defined.
- col_idx  output  2  column index the next accepted beat is written to.
- state_out  output  128  last completed state; column c occupies bits [127-32c -: 32], row 0 in the MSB byte.
- state_valid  output  1  one-cycle pulse when state_out is updated.

## Operation

- FSM states: IDLE, COLLECT.
- IDLE: in_ready=0. start=1 -> COLLECT, col_idx<=0, working register cleared.
- COLLECT: in_ready=1. Beat accepted when in_valid && in_ready.
- Beat at column c, default placement: working[127-32c -: 32] <= {in_1,in_2,in_3,in_4}; col_idx <= c+1, 2-bit, wraps 3->0.
- Beat at c=3: state_out <= working with column 3 merged, same edge; state_valid=1 for one cycle; FSM -> IDLE; col_idx -> 0.
- start while in COLLECT: restarts, col_idx<=0, working cleared, partial data discarded. A concurrent in_valid beat is dropped because start has priority. state_out and state_valid are not affected.
- start on the same cycle as the completing beat: start wins. The beat is dropped, there is no state_valid, and the FSM stays in COLLECT with col_idx=0.
- in_valid while in IDLE: ignored.
- inv_sr is sampled per beat. With INV_SR_EN, byte of row r from column c goes to column (c+r) mod 4, row r.
- state_out holds its value until the next completion.

## Timing

- Reset values: in_ready=0, col_idx=0, state_out=128'h0, state_valid=0, FSM=IDLE, working=0.
- Reset asserted mid-collection: everything returns to the reset values immediately.
- start at edge N: in_ready=1 from N onward.
- Minimum start-to-state_valid is 5 edges: start plus 4 consecutive beats. state_valid is visible after the edge that accepts beat 3.
- Throughput: one beat per cycle. Back-to-back blocks need a start between them, so the minimum period is 5 cycles per block.
- All outputs are registered except in_ready, which is decoded from the FSM state.

## Configuration

- INV_SR_EN defined: the inv_sr input is honoured, and the per-row write column is (c+r) mod 4. This costs one 4:1 byte-lane mux per row.
- INV_SR_EN undefined: inv_sr is ignored, and placement is always straight (column c for every row).

## Test plan

- Reset: hold rst_n=0 -> state_out=0, state_valid=0, in_ready=0, col_idx=0. Assert rst_n mid-collection after 2 beats -> same values immediately, with no state_valid.
- Straight collect: start, then beats 00112233, 44556677, 8899aabb, ccddeeff on consecutive cycles -> state_out=00112233445566778899aabbccddeeff, state_valid pulses exactly one cycle, 5 edges after start.
- Inverse placement (INV_SR_EN, inv_sr=1): the same four beats -> state_out=00ddaa774411eebb885522ffcc996633. With the macro undefined, the same stimulus -> the straight result.
- Stalls: in_valid low for 3 cycles between beats 1 and 2 -> col_idx holds at 2, result is identical, and state_valid arrives 3 cycles later.
- Abort: start again after 2 beats, then 4 new beats ffeeddcc, bbaa9988, 77665544, 33221100 -> state_out=ffeeddccbbaa99887766554433221100, with only one state_valid pulse.
- Boundary: start coincident with beat 3 -> no state_valid, col_idx=0. in_valid while IDLE -> no change; the previous state_out is held.
